// File: rtl/otter_uart_pkg.sv
// rtl/otter_uart_pkg.sv - shared types and divisor helper for the OTTER UART transmitter
package otter_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

   localparam int DIV_MAX = 65535;
   localparam int DIV_W   = $clog2(DIV_MAX + 1);

   // Rounded to nearest so the bit period error stays under half a clock.
   function automatic int calc_div(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/otter_sync_fifo.sv
// rtl/otter_sync_fifo.sv - small synchronous FIFO with wrap-bit pointers
module otter_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // The extra pointer bit separates full from empty when the indices match.
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/otter_uart_tx.sv
// rtl/otter_uart_tx.sv - buffered 8N1-style UART transmitter for the OTTER wrapper
module otter_uart_tx
   import otter_uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 115_200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [DATA_BITS-1:0] TX_DATA,
   input  logic                 TX_VALID,
   output logic                 TX_READY,
   output logic                 TX,
   output logic                 BUSY
);

   localparam int DIV   = calc_div(CLK_FREQ, BAUD);
   localparam int CNT_W = DIV_W + 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * DIV - 1);
   localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

   uart_tx_state_t       state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic [DATA_BITS-1:0] fifo_dout;

   otter_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (TX_VALID),
      .pop   (fifo_pop),
      .din   (TX_DATA),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign TX_READY = !fifo_full;
   assign TX       = tx_q;
   assign BUSY     = (state_q != IDLE) || !fifo_empty;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_dout;
               state_d  = START;
               tx_d     = 1'b0;
            end
         end
         START: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[1];
               end
            end
         end
         STOP: begin
            // A queued byte starts its frame on the very next edge: no idle gap.
            if (cnt_q == STOP_LAST) begin
               cnt_d = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_dout;
                  state_d  = START;
                  tx_d     = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule
